// File: rtl/taylor_horner_sched_pkg.sv
// Shared definitions for the exp() Taylor/Horner sequencer.
//   state_t    : FSM state encodings (IDLE, LOAD, MUL, ADD, DONE), 3 bits.
//   SEL_LOAD   : multiplier operand taken from the load register (first round).
//   SEL_ACC    : multiplier operand taken from acc.
//   ADD_TO_OUT : adder result goes to the output register (final round).
//   ADD_TO_ACC : adder result goes back to acc.
//   CNT_W      : width of the shared latency counter (latencies 1..4).
//   params_ok  : parameter-range check used at elaboration by the top.
package taylor_horner_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MUL  = 3'd2,
    ST_ADD  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic SEL_LOAD   = 1'b1;
  localparam logic SEL_ACC    = 1'b0;
  localparam logic ADD_TO_OUT = 1'b1;
  localparam logic ADD_TO_ACC = 1'b0;

  localparam int CNT_W = 2;

  function automatic bit params_ok(input int n_terms, input int mul_lat,
                                   input int add_lat, input int addr_w);
    return (n_terms >= 1) && (n_terms <= 8) &&
           (mul_lat >= 1) && (mul_lat <= 4) &&
           (add_lat >= 1) && (add_lat <= 4) &&
           ((1 << addr_w) >= n_terms);
  endfunction

endpackage

// File: rtl/taylor_lat_counter.sv
// Loadable down-counter that times the MUL and ADD holds. Loaded with
// latency-1 on entry to a hold; `last` is high on the final cycle of it.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (count cleared)
//   load     in   load load_val on the next edge
//   load_val in   CNT_W  remaining cycles after the first one
//   last     out  count is zero: current cycle is the last of the hold
module taylor_lat_counter
  import taylor_horner_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign last = (cnt_reg == '0);

endmodule

// File: rtl/taylor_horner_sched.sv
// Horner sequencer for an N_TERMS exp() Taylor polynomial on one shared
// multiplier and one shared adder: acc = c[N-1]; acc = acc*x + c[k], k = N-2..0.
// Optional feature macro: TAYLOR_ABORT_EN (adds abort input / aborted output).
// Ports:
//   CLK          in   clock
//   rst          in   synchronous active-high reset
//   start        in   request an evaluation (sampled in IDLE only)
//   abort        in   (TAYLOR_ABORT_EN) cancel a running evaluation
//   aborted      out  (TAYLOR_ABORT_EN) one-cycle pulse after a cancel
//   busy         out  high in every state except IDLE
//   acc_load     out  load acc from ROM word coef_addr
//   coef_addr    out  coefficient ROM address
//   mul_ss       out  multiplier operand select (1: load reg, 0: acc)
//   mul_ss_en    out  multiplier enable
//   add_ss       out  adder destination select (1: output reg, 0: acc)
//   add_ss_en    out  adder enable
//   output_ready out  one-cycle pulse, result valid
module taylor_horner_sched
  import taylor_horner_sched_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int MUL_LAT = 1,
  parameter int ADD_LAT = 1,
  parameter int ADDR_W  = 3
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              acc_load,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mul_ss,
  output logic              mul_ss_en,
  output logic              add_ss,
  output logic              add_ss_en,
`ifdef TAYLOR_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              output_ready
);

  if (!params_ok(N_TERMS, MUL_LAT, ADD_LAT, ADDR_W)) begin : g_param_check
    $error("taylor_horner_sched: parameter out of range");
  end

  localparam logic [ADDR_W-1:0] COEF_TOP = ADDR_W'(N_TERMS - 1);
  // First-round index; with a single term there are no rounds and k stays 0.
  localparam logic [ADDR_W-1:0] K_FIRST  = ADDR_W'((N_TERMS > 1) ? N_TERMS - 2 : 0);
  localparam logic [CNT_W-1:0]  MUL_HOLD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0]  ADD_HOLD = CNT_W'(ADD_LAT - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] k_reg;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_last;
  logic              abort_hit;

`ifdef TAYLOR_ABORT_EN
  logic aborted_reg;

  assign abort_hit = abort && ((state_reg == ST_LOAD) || (state_reg == ST_MUL) ||
                               (state_reg == ST_ADD));

  always_ff @(posedge CLK) begin
    if (rst) begin
      aborted_reg <= 1'b0;
    end else begin
      aborted_reg <= abort_hit;
    end
  end

  assign aborted = aborted_reg && !rst;
`else
  assign abort_hit = 1'b0;
`endif

  // One counter serves both holds: it is reloaded on every entry to MUL or ADD.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = MUL_HOLD;
    case (state_reg)
      ST_LOAD: cnt_load = 1'b1;
      ST_MUL: begin
        cnt_load = cnt_last;
        cnt_val  = ADD_HOLD;
      end
      ST_ADD:  cnt_load = cnt_last && (k_reg != '0);
      default: cnt_load = 1'b0;
    endcase
  end

  taylor_lat_counter u_lat_counter (
    .clk      (CLK),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .last     (cnt_last)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
    end else if (abort_hit) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (start) state_reg <= ST_LOAD;
        ST_LOAD: begin
          k_reg     <= K_FIRST;
          state_reg <= (N_TERMS == 1) ? ST_DONE : ST_MUL;
        end
        ST_MUL:  if (cnt_last) state_reg <= ST_ADD;
        ST_ADD: begin
          if (cnt_last) begin
            if (k_reg == '0) begin
              state_reg <= ST_DONE;
            end else begin
              k_reg     <= k_reg - ADDR_W'(1);
              state_reg <= ST_MUL;
            end
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Moore decode; everything is forced to its idle value while rst is high.
  always_comb begin
    busy         = 1'b0;
    acc_load     = 1'b0;
    coef_addr    = COEF_TOP;
    mul_ss       = SEL_ACC;
    mul_ss_en    = 1'b0;
    add_ss       = ADD_TO_ACC;
    add_ss_en    = 1'b0;
    output_ready = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_LOAD: begin
          busy     = 1'b1;
          acc_load = 1'b1;
        end
        ST_MUL: begin
          busy      = 1'b1;
          mul_ss_en = 1'b1;
          coef_addr = k_reg;
          mul_ss    = (k_reg == K_FIRST) ? SEL_LOAD : SEL_ACC;
        end
        ST_ADD: begin
          busy      = 1'b1;
          add_ss_en = 1'b1;
          coef_addr = k_reg;
          add_ss    = (k_reg == '0) ? ADD_TO_OUT : ADD_TO_ACC;
        end
        ST_DONE: begin
          busy         = 1'b1;
          output_ready = 1'b1;
          coef_addr    = k_reg;
        end
        default: busy = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_taylor_horner_sched.sv
// Bench for taylor_horner_sched. Three instances:
//   0: N=4, ML=1, AL=1   1: N=4, ML=3, AL=2   2: N=1, ML=1, AL=1
// Observation word layout: {busy, acc_load, coef_addr[2:0], mul_ss, mul_ss_en,
//                           add_ss, add_ss_en, output_ready}
module tb_taylor_horner_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [3];
  logic       start_v [3];
  logic       busy_v  [3];
  logic       load_v  [3];
  logic [2:0] addr_v  [3];
  logic       mss_v   [3];
  logic       men_v   [3];
  logic       ass_v   [3];
  logic       aen_v   [3];
  logic       rdy_v   [3];
`ifdef TAYLOR_ABORT_EN
  logic       abort_v   [3];
  logic       aborted_v [3];
`endif

  taylor_horner_sched #(.N_TERMS(4), .MUL_LAT(1), .ADD_LAT(1), .ADDR_W(3)) u_a (
    .CLK(clk), .rst(rst_v[0]), .start(start_v[0]), .busy(busy_v[0]),
    .acc_load(load_v[0]), .coef_addr(addr_v[0]), .mul_ss(mss_v[0]),
    .mul_ss_en(men_v[0]), .add_ss(ass_v[0]), .add_ss_en(aen_v[0]),
`ifdef TAYLOR_ABORT_EN
    .abort(abort_v[0]), .aborted(aborted_v[0]),
`endif
    .output_ready(rdy_v[0]));

  taylor_horner_sched #(.N_TERMS(4), .MUL_LAT(3), .ADD_LAT(2), .ADDR_W(3)) u_b (
    .CLK(clk), .rst(rst_v[1]), .start(start_v[1]), .busy(busy_v[1]),
    .acc_load(load_v[1]), .coef_addr(addr_v[1]), .mul_ss(mss_v[1]),
    .mul_ss_en(men_v[1]), .add_ss(ass_v[1]), .add_ss_en(aen_v[1]),
`ifdef TAYLOR_ABORT_EN
    .abort(abort_v[1]), .aborted(aborted_v[1]),
`endif
    .output_ready(rdy_v[1]));

  taylor_horner_sched #(.N_TERMS(1), .MUL_LAT(1), .ADD_LAT(1), .ADDR_W(3)) u_c (
    .CLK(clk), .rst(rst_v[2]), .start(start_v[2]), .busy(busy_v[2]),
    .acc_load(load_v[2]), .coef_addr(addr_v[2]), .mul_ss(mss_v[2]),
    .mul_ss_en(men_v[2]), .add_ss(ass_v[2]), .add_ss_en(aen_v[2]),
`ifdef TAYLOR_ABORT_EN
    .abort(abort_v[2]), .aborted(aborted_v[2]),
`endif
    .output_ready(rdy_v[2]));

  typedef struct {
    int         inst;
    logic       start;
    logic [9:0] exp;
    logic       acare;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [9:0] obs(input int i);
    return {busy_v[i], load_v[i], addr_v[i], mss_v[i], men_v[i], ass_v[i], aen_v[i], rdy_v[i]};
  endfunction

  function automatic void add_row(input int inst, input logic st, input logic b,
                                  input logic ld, input logic [2:0] a, input logic ac,
                                  input logic ms, input logic me, input logic asl,
                                  input logic ae, input logic rd);
    vec_t v;
    v.inst  = inst;
    v.start = st;
    v.exp   = {b, ld, a, ms, me, asl, ae, rd};
    v.acare = ac;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Applies table rows lo..hi, one clock cycle per row; called at posedge+1.
  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      logic [9:0] got;
      logic [9:0] mask;
      got  = obs(tbl[i].inst);
      mask = tbl[i].acare ? 10'b11_111_11111 : 10'b11_000_11111;
      n_vec++;
      if (((got ^ tbl[i].exp) & mask) != 10'd0) begin
        n_err++;
        $display("FAIL vec%0d inst%0d: got %b expected %b mask %b", i, tbl[i].inst,
                 got, tbl[i].exp, mask);
      end
      start_v[tbl[i].inst] = tbl[i].start;
      @(posedge clk);
      #1;
    end
  endtask

  // Structural invariants on every instance, every cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if ((men_v[i] && aen_v[i]) || (load_v[i] && (men_v[i] || aen_v[i]))) begin
        n_err++;
        $display("FAIL invariant inst%0d: load %b mul_en %b add_en %b", i, load_v[i],
                 men_v[i], aen_v[i]);
      end
    end
  end

  int a_lo, a_hi, b_lo, b_hi, c_lo, c_hi;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_v[i]   = 1'b1;
      start_v[i] = 1'b0;
`ifdef TAYLOR_ABORT_EN
      abort_v[i] = 1'b0;
`endif
    end

    // Instance 0, N=4 ML=AL=1: cycles 0..9.
    a_lo = tbl.size();
    add_row(0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    add_row(0, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0);
    add_row(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    add_row(0, 0, 1, 0, 2, 1, 0, 0, 0, 1, 0);
    add_row(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add_row(0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0);
    add_row(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add_row(0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0);
    add_row(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add_row(0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    a_hi = tbl.size() - 1;

    // Instance 1, N=4 ML=3 AL=2: cycles 0..18, output_ready at 17.
    b_lo = tbl.size();
    add_row(1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    add_row(1, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) add_row(1, 0, 1, 0, 0, 0, (r == 0), 1, 0, 0, 0);
      for (int c = 0; c < 2; c++) add_row(1, 0, 1, 0, 3'(2 - r), 1, 0, 0, (r == 2), 1, 0);
    end
    add_row(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add_row(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    b_hi = tbl.size() - 1;

    // Instance 2, N=1: LOAD@1, DONE@2, no enables.
    c_lo = tbl.size();
    add_row(2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_row(2, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    add_row(2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
    add_row(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    c_hi = tbl.size() - 1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi_a", 32'(obs(0)), 32'(10'b00_011_00000));
    chk("rst_hi_c", 32'(obs(2)), 32'(10'b00_000_00000));
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
    @(posedge clk);
    #1;

    apply(a_lo, a_hi);
    apply(b_lo, b_hi);
    apply(c_lo, c_hi);

    // start held high: results at 8 and 17, idle gaps at 0, 9, 18.
    start_v[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("hold_rdy_c%0d", c), 32'(rdy_v[0]), 32'(c == 8 || c == 17));
      chk($sformatf("hold_busy_c%0d", c), 32'(busy_v[0]),
          32'(!(c == 0 || c == 9 || c == 18 || c == 19)));
      if (c == 18) start_v[0] = 1'b0;
      @(posedge clk);
      #1;
    end

    // rst during the second ADD (cycle 5), then a clean run.
    begin
      int rdy_cnt;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_mid_in_add", 32'({aen_v[0], addr_v[0]}), 32'({1'b1, 3'd1}));
      rst_v[0] = 1'b1;
      #1;
      chk("rst_mid_hi", 32'(obs(0)), 32'(10'b00_011_00000));
      @(posedge clk);
      #1;
      rst_v[0] = 1'b0;
      #1;
      chk("rst_mid_next", 32'(obs(0)), 32'(10'b00_011_00000));
      rdy_cnt = 0;
      for (int c = 0; c < 8; c++) begin
        @(posedge clk);
        #1;
        if (rdy_v[0] || busy_v[0]) rdy_cnt++;
      end
      chk("rst_mid_quiet", 32'(rdy_cnt), 32'd0);
      apply(a_lo, a_hi);
    end

`ifdef TAYLOR_ABORT_EN
    // abort in the first MUL (cycle 2).
    begin
      int rdy_cnt;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_in_mul", 32'(men_v[0]), 32'd1);
      abort_v[0] = 1'b1;
      @(posedge clk);
      #1;
      abort_v[0] = 1'b0;
      chk("abort_pulse", 32'({aborted_v[0], busy_v[0], men_v[0]}), 32'(3'b100));
      @(posedge clk);
      #1;
      chk("abort_pulse_end", 32'(aborted_v[0]), 32'd0);
      rdy_cnt = 0;
      for (int c = 0; c < 8; c++) begin
        if (rdy_v[0] || busy_v[0]) rdy_cnt++;
        @(posedge clk);
        #1;
      end
      chk("abort_quiet", 32'(rdy_cnt), 32'd0);
      apply(a_lo, a_hi);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
